// File: rtl/pwm_pkg.sv
// Shared PWM constants and the duty-compare helper.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package pwm_pkg;

    localparam int PWM_CNT_W = 8;
    localparam int NUM_OUT   = 16;
    localparam int DIV_W     = 16;

    localparam logic [PWM_CNT_W-1:0] DUTY_FULL = 8'hFF;

    // Full-scale duty is forced high so 0xFF never drops for the counter-255 step.
    function automatic logic pwm_level_f(input logic [PWM_CNT_W-1:0] cnt,
                                         input logic [PWM_CNT_W-1:0] duty);
        return (duty == DUTY_FULL) || (cnt < duty);
    endfunction

endpackage

// File: rtl/pwm_generator_if.sv
// Bundle of PWM control inputs and pin outputs between a register block and the generator.
// Latency: n/a (wires only).
// Backpressure: none; levels are sampled every clk.
interface pwm_generator_if;

    logic [pwm_pkg::NUM_OUT-1:0]   en_out;
    logic [pwm_pkg::NUM_OUT-1:0]   en_pwm;
    logic [pwm_pkg::PWM_CNT_W-1:0] duty;
    logic [pwm_pkg::NUM_OUT-1:0]   out;
    logic                          period_start;

    modport master (output en_out, en_pwm, duty, input  out, period_start);
    modport slave  (input  en_out, en_pwm, duty, output out, period_start);

endinterface

// File: rtl/pwm_prescaler.sv
// Clock divider producing a one-clk tick every CLK_DIV clks.
// Latency: first tick no earlier than the second clk after reset release.
// Backpressure: none; free-running.
module pwm_prescaler
    import pwm_pkg::*;
#(
    parameter int unsigned CLK_DIV = 3000
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_ONE  = 1;

    logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
    logic             run_q, run_d;

    // run_q masks the reset-release clk, which matters only when CLK_DIV is 1.
    always_comb begin
        run_d     = 1'b1;
        tick      = run_q && (div_cnt_q == DIV_LAST);
        div_cnt_d = div_cnt_q + DIV_ONE;
        if (div_cnt_q == DIV_LAST) begin
            div_cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt_q <= '0;
            run_q     <= 1'b0;
        end else begin
            div_cnt_q <= div_cnt_d;
            run_q     <= run_d;
        end
    end

endmodule

// File: rtl/pwm_generator.sv
// 16-output PWM generator sharing one 8-bit counter; PWM_SHADOW_EN defers duty changes to period start.
// Latency: out is registered, 1 clk from any input change.
// Backpressure: none; inputs are sampled every clk.
module pwm_generator
    import pwm_pkg::*;
#(
    parameter int unsigned CLK_DIV = 3000
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [7:0]         en_reg_out_7_0,
    input  logic [7:0]         en_reg_out_15_8,
    input  logic [7:0]         en_reg_pwm_7_0,
    input  logic [7:0]         en_reg_pwm_15_8,
    input  logic [7:0]         pwm_duty_cycle,
    output logic [NUM_OUT-1:0] out,
    output logic               period_start
);

    localparam logic [PWM_CNT_W-1:0] CNT_LAST = '1;
    localparam logic [PWM_CNT_W-1:0] CNT_ONE  = 1;

    logic                 tick;
    logic [PWM_CNT_W-1:0] pwm_cnt_q, pwm_cnt_d;
    logic [PWM_CNT_W-1:0] active_duty;
    logic [NUM_OUT-1:0]   en_out, en_pwm;
    logic [NUM_OUT-1:0]   out_q, out_d;
    logic                 pwm_level;

    pwm_prescaler #(.CLK_DIV(CLK_DIV)) u_prescaler (
        .clk   (clk),
        .rst_n (rst_n),
        .tick  (tick)
    );

    assign en_out = {en_reg_out_15_8, en_reg_out_7_0};
    assign en_pwm = {en_reg_pwm_15_8, en_reg_pwm_7_0};

`ifdef PWM_SHADOW_EN
    logic [PWM_CNT_W-1:0] duty_q, duty_d;

    always_comb begin
        duty_d = duty_q;
        if (period_start) begin
            duty_d = pwm_duty_cycle;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            duty_q <= '0;
        end else begin
            duty_q <= duty_d;
        end
    end

    assign active_duty = duty_q;
`else
    assign active_duty = pwm_duty_cycle;
`endif

    // All outputs compare against one counter, so PWM edges stay phase-aligned.
    always_comb begin
        pwm_cnt_d    = pwm_cnt_q;
        period_start = tick && (pwm_cnt_q == CNT_LAST);
        if (tick) begin
            pwm_cnt_d = pwm_cnt_q + CNT_ONE;
        end
        pwm_level = pwm_level_f(pwm_cnt_q, active_duty);
        out_d     = en_out & (~en_pwm | {NUM_OUT{pwm_level}});
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pwm_cnt_q <= '0;
            out_q     <= '0;
        end else begin
            pwm_cnt_q <= pwm_cnt_d;
            out_q     <= out_d;
        end
    end

    assign out = out_q;

endmodule

// File: tb/tb_pwm_generator.sv
// Scoreboarded bench: per-period high-time of every output is checked at each period_start.
// Directed enable/duty vectors with hand-derived high counts; reset and 1-clk latency checked inline.
module tb_pwm_generator;

    localparam int unsigned DIV = 4;
    localparam int          PER = 256 * DIV;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    pwm_generator_if bus ();

    pwm_generator #(.CLK_DIV(DIV)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .en_reg_out_7_0  (bus.en_out[7:0]),
        .en_reg_out_15_8 (bus.en_out[15:8]),
        .en_reg_pwm_7_0  (bus.en_pwm[7:0]),
        .en_reg_pwm_15_8 (bus.en_pwm[15:8]),
        .pwm_duty_cycle  (bus.duty),
        .out             (bus.out),
        .period_start    (bus.period_start)
    );

    typedef struct packed {
        logic              ign;
        logic [7:0]        tag;
        logic [15:0][10:0] hi;
    } exp_t;

    exp_t sb_q[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Expected high clks per window: disabled=0, static-on=whole period, PWM=pwm_hi.
    function automatic exp_t make_exp(input logic [7:0] tag, input logic ign,
                                      input logic [15:0] eo, input logic [15:0] ep,
                                      input int pwm_hi);
        exp_t e;
        e.ign = ign;
        e.tag = tag;
        for (int i = 0; i < 16; i++) begin
            if (!eo[i])      e.hi[i] = 11'd0;
            else if (!ep[i]) e.hi[i] = 11'(PER);
            else             e.hi[i] = 11'(pwm_hi);
        end
        return e;
    endfunction

    // Monitor: accumulate out between period_start pulses, compare against the queue head.
    int   acc [16];
    int   win_len;
    bit   win_vld;
    exp_t cur;

    always @(negedge clk) begin
        if (!rst_n) begin
            win_vld = 1'b0;
            win_len = 0;
            for (int i = 0; i < 16; i++) acc[i] = 0;
        end else begin
            for (int i = 0; i < 16; i++) acc[i] += int'(bus.out[i]);
            win_len++;
            if (bus.period_start) begin
                if (win_vld && sb_q.size() > 0) begin
                    cur = sb_q.pop_front();
                    if (!cur.ign) begin
                        chk($sformatf("win%0d_len", cur.tag), win_len, PER);
                        for (int i = 0; i < 16; i++)
                            chk($sformatf("win%0d_bit%0d_high", cur.tag, i), acc[i], int'(cur.hi[i]));
                    end
                end
                win_vld = 1'b1;
                win_len = 0;
                for (int i = 0; i < 16; i++) acc[i] = 0;
            end
        end
    end

    task automatic wait_ps();
        int k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!bus.period_start && k < 3 * PER);
        if (!bus.period_start) chk("period_start_timeout", 0, 1);
        #1;
    endtask

    task automatic apply(input logic [15:0] eo, input logic [15:0] ep, input logic [7:0] d);
        bus.en_out = eo;
        bus.en_pwm = ep;
        bus.duty   = d;
    endtask

    // Called just after a period_start; first window after a change is discarded.
    task automatic run_cfg(input logic [7:0] tag, input logic [15:0] eo, input logic [15:0] ep,
                           input logic [7:0] d, input int pwm_hi, input int n);
        apply(eo, ep, d);
        sb_q.push_back(make_exp(tag, 1'b1, eo, ep, pwm_hi));
        repeat (n) sb_q.push_back(make_exp(tag, 1'b0, eo, ep, pwm_hi));
        repeat (n + 1) wait_ps();
    endtask

    initial begin
        int n;
        apply(16'h0000, 16'h0000, 8'h00);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_out", int'(bus.out), 0);
        chk("rst_period_start", int'(bus.period_start), 0);
        rst_n = 1'b1;
        wait_ps();

        chk("pre_enable_out", int'(bus.out), 0);
        apply(16'hFFFF, 16'h0000, 8'h80);
        sb_q.push_back(make_exp(8'd1, 1'b1, 16'hFFFF, 16'h0000, 0));
        sb_q.push_back(make_exp(8'd1, 1'b0, 16'hFFFF, 16'h0000, 0));
        @(posedge clk);
        #1;
        chk("enable_one_clk", int'(bus.out), 16'hFFFF);
        repeat (2) wait_ps();

        run_cfg(8'd2, 16'hFFFF, 16'hFFFF, 8'h80, 512, 2);
        run_cfg(8'd3, 16'hFFFF, 16'hFFFF, 8'h00, 0, 3);
        run_cfg(8'd4, 16'hFFFF, 16'hFFFF, 8'hFF, PER, 3);
        run_cfg(8'd5, 16'h00FF, 16'h0F0F, 8'h40, 256, 1);

        // Duty 0x40 -> 0xC0 when the counter reaches 100.
        apply(16'hFFFF, 16'hFFFF, 8'h40);
        sb_q.push_back(make_exp(8'd6, 1'b1, 16'hFFFF, 16'hFFFF, 256));
        sb_q.push_back(make_exp(8'd6, 1'b0, 16'hFFFF, 16'hFFFF, 256));
        repeat (2) wait_ps();
        repeat (1 + 100 * DIV) @(posedge clk);
        #1;
        bus.duty = 8'hC0;
`ifdef PWM_SHADOW_EN
        sb_q.push_back(make_exp(8'd7, 1'b0, 16'hFFFF, 16'hFFFF, 256));
`else
        sb_q.push_back(make_exp(8'd7, 1'b0, 16'hFFFF, 16'hFFFF, 64 * DIV + 92 * DIV));
`endif
        sb_q.push_back(make_exp(8'd8, 1'b0, 16'hFFFF, 16'hFFFF, 768));
        repeat (2) wait_ps();

        // Reset pulse at counter 200, then time the first wrap after release.
        apply(16'hFFFF, 16'h0000, 8'h00);
        repeat (1 + 200 * DIV) @(posedge clk);
        #1;
        chk("pre_reset_out", int'(bus.out), 16'hFFFF);
        rst_n = 1'b0;
        #1;
        chk("async_reset_out", int'(bus.out), 0);
        chk("async_reset_period_start", int'(bus.period_start), 0);
        repeat (3) @(negedge clk);
        chk("held_reset_out", int'(bus.out), 0);
        rst_n = 1'b1;
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!bus.period_start && n < 3 * PER);
        // period_start is high in the clk that ends on the wrap edge.
        chk("first_wrap_edge_after_release", n + 1, PER);

        chk("scoreboard_drained", sb_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
